print_fmt: RTL and testbench
============================

// Module: print_fmt
// PURPOSE
//  Parametrised formatter between the debug-unit command engine and the UART TX byte channel.
//  Latches one operand per request and emits it as ASCII on a byte valid/ready stream:
//  - raw byte
//  - grouped hex word + space
//  - grouped hex word + CR LF
//  - 2-digit hex byte + space
//  Successor to the fixed 32-bit byte/word printer: adds generic width, group size, line-end mode and operand latching.
// PARAMETERS
//  DW        32     operand width in bits; multiple of 4, range 8..64; ND = DW/4 hex digits
//  GROUP     4      hex digits per group; SEP_CHAR between groups, none after last; GROUP>=ND disables separators
//  SEP_CHAR  8'h2D  group separator ('-')
//  TERM_CHAR 8'h20  terminator for modes 1 and 3 (' ')
//  UPPER     1      1: hex digits A-F as 8'h41-46; 0: a-f as 8'h61-66
// PORTS
//  clk      in   1   single clock; all logic on posedge
//  rstn     in   1   asynchronous active-low reset
//  dout_tx  in   DW  operand; sampled only in the request-accept cycle
//  type_tx  in   2   mode; sampled with dout_tx: 0 raw dout_tx[7:0], 1 hex+TERM, 2 hex+CR LF, 3 hex of [7:0]+TERM
//  req_tx   in   1   print request (four-phase with ack_tx)
//  ack_tx   out  1   message complete; high until req_tx sampled low
//  busy     out  1   high from request accept until ack_tx falls
//  d_tx     out  8   byte to UART TX
//  vld_tx   out  1   d_tx valid
//  rdy_tx   in   1   UART TX can take a byte; transfer = vld_tx & rdy_tx on a posedge
// BEHAVIOUR
//  Reset: async on rstn low; state IDLE; ack_tx=0, busy=0, vld_tx=0, d_tx=8'h00, counters 0.
//  Reset mid-message: partial message dropped, no further bytes, no ack_tx.
//  States: IDLE -> SEND -> DONE -> IDLE.
//  IDLE:
//  - accept when req_tx=1 and ack_tx=0
//  - same edge: latch dout_tx/type_tx, load first byte into d_tx, set vld_tx=1, busy=1
//  - first byte valid 1 cycle after req_tx seen
//  SEND:
//  - d_tx and vld_tx held stable while vld_tx & !rdy_tx
//  - on transfer: next byte presented on the following cycle with vld_tx kept high (1 byte/clk when rdy_tx stays high)
//  - no idle gap between bytes of one message
//  - on transfer of last byte: vld_tx=0, ack_tx=1, go to DONE
//  DONE:
//  - ack_tx held while req_tx=1
//  - req_tx sampled 0 -> ack_tx=0, busy=0, IDLE
//  - no new accept is possible in the cycle ack_tx falls
//  Byte sequence:
//  - mode 0: dout_tx[7:0] only (1 byte)
//  - mode 1/2: ND digits MS nibble first, SEP_CHAR after every GROUP digits except the last; then TERM_CHAR (mode 1) or 8'h0D,8'h0A (mode 2)
//  - mode 3: digits of [7:0] then TERM_CHAR (3 bytes)
//  Message length = digits + floor((ND-1)/GROUP) + terminators; index counter width $clog2(ND+ND/GROUP+3).
//  Digit map: 0-9 -> 8'h30-39; 10-15 -> per UPPER.
//  Changes on dout_tx/type_tx/req_tx during SEND are ignored.
//  rdy_tx low at accept is legal; first byte waits under vld_tx.
// STRUCTURE
//  Package print_fmt_pkg:
//  - mode localparams MODE_RAW/MODE_HEX_SP/MODE_HEX_CRLF/MODE_BYTE_SP
//  - ASCII constants CR, LF, ZERO, 'A', 'a'
//  - state encoding
//  Sub-module hex2ascii (4-bit nibble + UPPER -> 8-bit ASCII, combinational), single instance on the nibble mux.
//  Top: state reg, byte-index counter, digit-position counter, group counter, latched operand/mode regs, output regs.
// TESTING
//  1 mode1, DW=32, dout_tx=32'h1234ABCD, rdy_tx=1 -> d_tx "1234-ABCD ", 10 consecutive transfers, ack_tx next cycle.
//  2 mode0, dout_tx[7:0]=8'h5A -> single byte 8'h5A; rdy_tx low 3 cycles: d_tx/vld_tx stable until transfer.
//  3 mode2, dout_tx=32'h0000FFFF, UPPER=0 -> "0000-ffff",8'h0D,8'h0A; random rdy_tx stalls leave order unchanged.
//  4 DW=64, GROUP=8, mode1, 64'h0123456789ABCDEF -> "01234567-89ABCDEF " (18 bytes).
//  5 req_tx held high after ack_tx -> ack_tx stays 1, no 2nd message; req_tx low -> ack_tx=0, then new req accepted.
//  6 rstn pulsed low after 3rd byte of mode1 -> vld_tx=0, ack_tx=0 immediately; next req prints the full message.

Source files
------------

// File: rtl/print_fmt_pkg.sv
// print_fmt_pkg
//   Shared constants for the ASCII print formatter: operand print modes,
//   ASCII codes used when building messages, and the FSM state encoding.
package print_fmt_pkg;

  localparam logic [1:0] MODE_RAW      = 2'd0;  // raw operand byte
  localparam logic [1:0] MODE_HEX_SP   = 2'd1;  // grouped hex word + TERM_CHAR
  localparam logic [1:0] MODE_HEX_CRLF = 2'd2;  // grouped hex word + CR LF
  localparam logic [1:0] MODE_BYTE_SP  = 2'd3;  // two hex digits + TERM_CHAR

  localparam logic [7:0] ASC_CR   = 8'h0D;
  localparam logic [7:0] ASC_LF   = 8'h0A;
  localparam logic [7:0] ASC_ZERO = 8'h30;
  localparam logic [7:0] ASC_UC_A = 8'h41;
  localparam logic [7:0] ASC_LC_A = 8'h61;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/print_fmt_hex2ascii.sv
// hex2ascii
//   Combinational nibble to ASCII hex digit.
//   Ports:
//     nib  in  4  nibble value
//     ch   out 8  ASCII '0'-'9', then 'A'-'F' (UPPER=1) or 'a'-'f' (UPPER=0)
module hex2ascii
  import print_fmt_pkg::*;
#(
  parameter bit UPPER = 1'b1
) (
  input  logic [3:0] nib,
  output logic [7:0] ch
);

  always_comb begin
    if (nib < 4'd10) ch = ASC_ZERO + {4'd0, nib};
    else             ch = (UPPER ? ASC_UC_A : ASC_LC_A) + {4'd0, nib} - 8'd10;
  end

endmodule

// File: rtl/print_fmt.sv
// print_fmt
//   Formats one latched operand per request as ASCII on a byte valid/ready
//   stream towards the UART transmitter. Four-phase req/ack handshake.
//   Ports:
//     clk      in   1   clock
//     rstn     in   1   asynchronous active-low reset
//     dout_tx  in   DW  operand, sampled at request accept
//     type_tx  in   2   print mode, sampled at request accept
//     req_tx   in   1   print request
//     ack_tx   out  1   message complete, held until req_tx drops
//     busy     out  1   request in progress
//     d_tx     out  8   byte to UART
//     vld_tx   out  1   d_tx valid
//     rdy_tx   in   1   UART accepts byte
//
//   state   | meaning
//   IDLE    | waiting for req_tx
//   SEND    | presenting message bytes on d_tx/vld_tx
//   DONE    | message complete, ack_tx high until req_tx falls
module print_fmt
  import print_fmt_pkg::*;
#(
  parameter int         DW        = 32,
  parameter int         GROUP     = 4,
  parameter logic [7:0] SEP_CHAR  = 8'h2D,
  parameter logic [7:0] TERM_CHAR = 8'h20,
  parameter bit         UPPER     = 1'b1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] dout_tx,
  input  logic [1:0]    type_tx,
  input  logic          req_tx,
  output logic          ack_tx,
  output logic          busy,
  output logic [7:0]    d_tx,
  output logic          vld_tx,
  input  logic          rdy_tx
);

  localparam int ND   = DW / 4;
  localparam int NSEP = (ND - 1) / GROUP;
  localparam int IW   = $clog2(ND + ND / GROUP + 3);
  localparam int DGW  = $clog2(ND + 1);
  localparam int GW   = $clog2(GROUP + 1);

  localparam logic [IW-1:0]  LEN_RAW   = IW'(1);
  localparam logic [IW-1:0]  LEN_HSP   = IW'(ND + NSEP + 1);
  localparam logic [IW-1:0]  LEN_HCRLF = IW'(ND + NSEP + 2);
  localparam logic [IW-1:0]  LEN_BSP   = IW'(3);
  localparam logic [DGW-1:0] ND_W      = DGW'(ND);
  localparam logic [DGW-1:0] ND_BYTE   = DGW'(2);
  localparam logic [GW-1:0]  GROUP_W   = GW'(GROUP);

  function automatic logic [IW-1:0] msg_len(input logic [1:0] m);
    case (m)
      MODE_RAW:      return LEN_RAW;
      MODE_HEX_SP:   return LEN_HSP;
      MODE_HEX_CRLF: return LEN_HCRLF;
      default:       return LEN_BSP;
    endcase
  endfunction

  state_t         state_q, state_d;
  logic [DW-1:0]  op_q, op_d;
  logic [1:0]     mode_q, mode_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [DGW-1:0] dig_q, dig_d;
  logic [GW-1:0]  grp_q, grp_d;
  logic [7:0]     d_d;
  logic           vld_d, ack_d, busy_d;

  // Byte generator: produces the byte at position g_idx and the digit/group
  // counters that follow it. In IDLE it works straight off the inputs so the
  // first byte can be loaded on the accept edge.
  logic [DW-1:0]  g_op;
  logic [1:0]     g_mode;
  logic [IW-1:0]  g_idx, g_len;
  logic [DGW-1:0] g_dig, g_nd, g_pos, g_dig_n;
  logic [GW-1:0]  g_grp, g_grp_n;
  logic [3:0]     g_nib;
  logic [7:0]     g_hex, g_byte;

  hex2ascii #(.UPPER(UPPER)) u_hex2ascii (
    .nib (g_nib),
    .ch  (g_hex)
  );

  always_comb begin
    if (state_q == ST_IDLE) begin
      g_op   = dout_tx;
      g_mode = type_tx;
      g_idx  = '0;
      g_dig  = '0;
      g_grp  = '0;
    end else begin
      g_op   = op_q;
      g_mode = mode_q;
      g_idx  = idx_q;
      g_dig  = dig_q;
      g_grp  = grp_q;
    end
    g_len   = msg_len(g_mode);
    g_nd    = (g_mode == MODE_BYTE_SP) ? ND_BYTE : ND_W;
    g_pos   = g_nd - g_dig - DGW'(1);
    g_nib   = 4'(g_op >> {g_pos, 2'b00});
    g_byte  = TERM_CHAR;
    g_dig_n = g_dig;
    g_grp_n = g_grp;
    if (g_mode == MODE_RAW) begin
      g_byte = g_op[7:0];
    end else if (g_dig < g_nd) begin
      // a full group with digits still pending means a separator comes first
      if (g_mode != MODE_BYTE_SP && g_grp == GROUP_W) begin
        g_byte  = SEP_CHAR;
        g_grp_n = '0;
      end else begin
        g_byte  = g_hex;
        g_dig_n = g_dig + DGW'(1);
        g_grp_n = g_grp + GW'(1);
      end
    end else if (g_mode == MODE_HEX_CRLF) begin
      g_byte = (g_idx == g_len - IW'(2)) ? ASC_CR : ASC_LF;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    dig_d   = dig_q;
    grp_d   = grp_q;
    d_d     = d_tx;
    vld_d   = vld_tx;
    ack_d   = ack_tx;
    busy_d  = busy;
    case (state_q)
      ST_IDLE: begin
        if (req_tx && !ack_tx) begin
          state_d = ST_SEND;
          op_d    = dout_tx;
          mode_d  = type_tx;
          d_d     = g_byte;
          vld_d   = 1'b1;
          busy_d  = 1'b1;
          idx_d   = IW'(1);
          dig_d   = g_dig_n;
          grp_d   = g_grp_n;
        end
      end
      ST_SEND: begin
        if (vld_tx && rdy_tx) begin
          // idx_q counts bytes already generated; equal to length means
          // the byte just taken was the last one
          if (idx_q == g_len) begin
            vld_d   = 1'b0;
            ack_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            d_d   = g_byte;
            idx_d = idx_q + IW'(1);
            dig_d = g_dig_n;
            grp_d = g_grp_n;
          end
        end
      end
      ST_DONE: begin
        if (!req_tx) begin
          ack_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      mode_q  <= MODE_RAW;
      idx_q   <= '0;
      dig_q   <= '0;
      grp_q   <= '0;
      d_tx    <= 8'h00;
      vld_tx  <= 1'b0;
      ack_tx  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      grp_q   <= grp_d;
      d_tx    <= d_d;
      vld_tx  <= vld_d;
      ack_tx  <= ack_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_print_fmt.sv
// tb_print_fmt
//   Three formatter instances (32-bit upper case, 32-bit lower case, 64-bit
//   with 8-digit groups) share one request/ready stimulus; each byte stream is
//   compared against a string-building reference model.
module tb_print_fmt;

  typedef byte unsigned bq_t[$];
  typedef int iq_t[$];

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [63:0] dout = '0;
  logic [1:0]  typ = '0;
  logic        req = 1'b0;
  logic        rdy = 1'b0;
  logic [2:0]  ack, busy, vld;
  logic [7:0]  d_tx [3];

  bit hold_low = 1'b0;
  bit rnd = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  bq_t  got [3];
  iq_t  xc [3];
  logic stall [3];
  logic [7:0] stall_d [3];

  int cfg_dw  [3] = '{32, 32, 64};
  int cfg_grp [3] = '{4, 4, 8};
  bit cfg_up  [3] = '{1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  print_fmt #(.DW(32), .GROUP(4), .UPPER(1'b1)) u_w32 (
    .clk(clk), .rstn(rstn), .dout_tx(dout[31:0]), .type_tx(typ), .req_tx(req),
    .ack_tx(ack[0]), .busy(busy[0]), .d_tx(d_tx[0]), .vld_tx(vld[0]), .rdy_tx(rdy));

  print_fmt #(.DW(32), .GROUP(4), .UPPER(1'b0)) u_w32l (
    .clk(clk), .rstn(rstn), .dout_tx(dout[31:0]), .type_tx(typ), .req_tx(req),
    .ack_tx(ack[1]), .busy(busy[1]), .d_tx(d_tx[1]), .vld_tx(vld[1]), .rdy_tx(rdy));

  print_fmt #(.DW(64), .GROUP(8), .UPPER(1'b1)) u_w64 (
    .clk(clk), .rstn(rstn), .dout_tx(dout), .type_tx(typ), .req_tx(req),
    .ack_tx(ack[2]), .busy(busy[2]), .d_tx(d_tx[2]), .vld_tx(vld[2]), .rdy_tx(rdy));

  // ready driver, a little after the falling edge so flag updates are seen
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (hold_low)  rdy = 1'b0;
      else if (rnd)  rdy = 1'($urandom_range(0, 1));
      else           rdy = 1'b1;
    end
  end

  // transfer monitor
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      stall[i]   <= rstn && vld[i] && !rdy;
      stall_d[i] <= d_tx[i];
      if (rstn && vld[i] && rdy) begin
        got[i].push_back(d_tx[i]);
        xc[i].push_back(cyc);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic bq_t model(int dw, int grp, bit up, logic [1:0] m, logic [63:0] v);
    bq_t q;
    string hx;
    int nd;
    logic [63:0] t;
    hx = up ? "0123456789ABCDEF" : "0123456789abcdef";
    if (m == 2'd0) begin
      q.push_back(v[7:0]);
      return q;
    end
    nd = (m == 2'd3) ? 2 : dw / 4;
    for (int i = 0; i < nd; i++) begin
      if (m != 2'd3 && i > 0 && i % grp == 0) q.push_back(8'h2D);
      t = v >> (4 * (nd - 1 - i));
      q.push_back(hx[t[3:0]]);
    end
    if (m == 2'd2) begin
      q.push_back(8'h0D);
      q.push_back(8'h0A);
    end else begin
      q.push_back(8'h20);
    end
    return q;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] m, input logic [63:0] v, input int stall_n, input bit tim);
    bq_t e [3];
    int base [3];
    int bc [3];
    int ac [3];
    int n;
    int last;
    for (int i = 0; i < 3; i++) begin
      e[i] = model(cfg_dw[i], cfg_grp[i], cfg_up[i], m, v);
      base[i] = got[i].size();
      bc[i] = -1;
      ac[i] = -1;
    end
    @(negedge clk);
    dout = v;
    typ = m;
    req = 1'b1;
    hold_low = (stall_n > 0);
    n = 0;
    while (ack !== 3'b111 && n < 400) begin
      @(negedge clk);
      n++;
      dout = {$urandom, $urandom};
      typ = 2'($urandom_range(0, 3));
      for (int i = 0; i < 3; i++) begin
        if (busy[i] && bc[i] < 0) bc[i] = cyc;
        if (ack[i] && ac[i] < 0) ac[i] = cyc;
        if (stall[i]) begin
          chk("hold_vld", vld[i], 1'b1);
          chk("hold_d", d_tx[i], stall_d[i]);
        end
        if (n <= stall_n) begin
          chk("stall_vld", vld[i], 1'b1);
          chk("stall_d", d_tx[i], e[i][0]);
        end
      end
      if (n == stall_n) hold_low = 1'b0;
    end
    hold_low = 1'b0;
    chk("ack_wait", ack, 3'b111);
    for (int i = 0; i < 3; i++) begin
      chk("msg_len", got[i].size() - base[i], e[i].size());
      for (int k = 0; k < e[i].size() && base[i] + k < got[i].size(); k++)
        chk("msg_byte", got[i][base[i] + k], e[i][k]);
      if (tim && got[i].size() - base[i] == e[i].size()) begin
        last = base[i] + e[i].size() - 1;
        chk("first_lat", xc[i][base[i]], bc[i]);
        chk("no_gap", xc[i][last] - xc[i][base[i]], e[i].size() - 1);
        chk("ack_lat", ac[i], xc[i][last] + 1);
      end
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("ack_hold", ack[i], 1'b1);
      chk("busy_hold", busy[i], 1'b1);
      chk("vld_idle", vld[i], 1'b0);
      chk("no_second", got[i].size() - base[i], e[i].size());
    end
    req = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("ack_fall", ack[i], 1'b0);
      chk("busy_fall", busy[i], 1'b0);
    end
  endtask

  initial begin
    int b0;
    int n;
    bit s_rnd;
    int s_stall;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_d", d_tx[i], 8'h00);
      chk("rst_vld", vld[i], 1'b0);
      chk("rst_ack", ack[i], 1'b0);
      chk("rst_busy", busy[i], 1'b0);
    end
    rstn = 1'b1;
    @(negedge clk);

    send(2'd1, 64'h1234ABCD, 0, 1'b1);
    send(2'd0, 64'h5A, 3, 1'b0);
    rnd = 1'b1;
    send(2'd2, 64'h0000FFFF, 0, 1'b0);
    rnd = 1'b0;
    send(2'd1, 64'h0123456789ABCDEF, 0, 1'b1);
    send(2'd3, 64'hC3, 0, 1'b1);

    // reset in the middle of a message
    b0 = got[0].size();
    @(negedge clk);
    dout = 64'hDEADBEEF;
    typ = 2'd1;
    req = 1'b1;
    n = 0;
    while (got[0].size() - b0 < 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_wait", got[0].size() - b0, 3);
    rstn = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("mid_rst_vld", vld[i], 1'b0);
      chk("mid_rst_ack", ack[i], 1'b0);
      chk("mid_rst_busy", busy[i], 1'b0);
    end
    req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_quiet", got[0].size() - b0, 3);
    rstn = 1'b1;
    send(2'd1, 64'hDEADBEEF, 0, 1'b1);

    for (int r = 0; r < 24; r++) begin
      s_rnd = 1'($urandom_range(0, 1));
      s_stall = $urandom_range(0, 2);
      rnd = s_rnd;
      send(2'($urandom_range(0, 3)), {$urandom, $urandom}, s_stall, !s_rnd && s_stall == 0);
    end
    rnd = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
